// File: rtl/sensor_seq_ctrl_if.sv
// sensor_seq_ctrl_if: phase handshake between the sequencer and the bus engine
interface sensor_seq_ctrl_if #(parameter int IW = 2);
  logic [4:0]    o_phase;
  logic          o_cmd_start;
  logic [IW-1:0] o_cfg_idx;
  logic          i_phase_done;
  logic          i_nack;
  logic          i_conf_mismatch;
  modport master(output o_phase, o_cmd_start, o_cfg_idx, input i_phase_done, i_nack, i_conf_mismatch);
  modport slave(input o_phase, o_cmd_start, o_cfg_idx, output i_phase_done, i_nack, i_conf_mismatch);
endinterface

// File: rtl/sensor_seq_ctrl.sv
// sensor_seq_ctrl: address / configure-verify / read sequencer with retry limits and sticky fault
module sensor_seq_ctrl #(
  parameter int ACK_RETRIES = 10,
  parameter int CONF_RETRIES = 10,
  parameter int N_CONF = 4,
  localparam int CW = $clog2((ACK_RETRIES > CONF_RETRIES ? ACK_RETRIES : CONF_RETRIES) + 1),
  localparam int IW = N_CONF > 1 ? $clog2(N_CONF) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic                     i_clear,
  sensor_seq_ctrl_if.master        bus,
  output logic                     o_sample_wr,
  output logic [1:0]               o_fault_code,
  output logic [3:0]               o_fault_phase,
  output logic [CW-1:0]            o_nack_cnt,
  output logic                     o_busy
);
  // one-hot encoding doubles as the registered o_phase value
  typedef enum logic [4:0] {
    IDLE      = 5'b00000,
    ADDR      = 5'b00001,
    CFG_WRITE = 5'b00010,
    CFG_READ  = 5'b00100,
    READING   = 5'b01000,
    FAULT     = 5'b10000
  } state_t;
  state_t state, state_n;
  logic [CW-1:0] conf_cnt, nack_n, conf_n, nack_inc, conf_inc;
  logic [IW-1:0] idx_n;
  logic [1:0] code_n;
  logic [3:0] fph_n;
  logic cmd_n, wr_n;
  assign nack_inc = o_nack_cnt + 1'b1;
  assign conf_inc = conf_cnt + 1'b1;
  assign bus.o_phase = state;
  assign o_busy = |state[3:0];
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      o_nack_cnt <= '0;
      conf_cnt <= '0;
      bus.o_cfg_idx <= '0;
      o_fault_code <= '0;
      o_fault_phase <= '0;
      bus.o_cmd_start <= 1'b0;
      o_sample_wr <= 1'b0;
    end else begin
      state <= state_n;
      o_nack_cnt <= nack_n;
      conf_cnt <= conf_n;
      bus.o_cfg_idx <= idx_n;
      o_fault_code <= code_n;
      o_fault_phase <= fph_n;
      bus.o_cmd_start <= cmd_n;
      o_sample_wr <= wr_n;
    end
  end
  always_comb begin
    state_n = state;
    nack_n = o_nack_cnt;
    conf_n = conf_cnt;
    idx_n = bus.o_cfg_idx;
    code_n = o_fault_code;
    fph_n = o_fault_phase;
    cmd_n = 1'b0;
    wr_n = 1'b0;
    if ((i_abort && state != IDLE) || (state == FAULT && i_clear) || (state == IDLE && i_start)) begin
      state_n = state == IDLE ? ADDR : IDLE;
      cmd_n = state == IDLE;
      nack_n = '0;
      conf_n = '0;
      idx_n = '0;
      code_n = '0;
      fph_n = '0;
    end else if (state != IDLE && state != FAULT && bus.i_phase_done) begin
      if (bus.i_nack) begin
        nack_n = nack_inc;
        if (nack_inc == CW'(ACK_RETRIES)) begin
          state_n = FAULT;
          code_n = state == READING ? 2'b11 : 2'b01;
          fph_n = state[3:0];
        end else
          cmd_n = 1'b1;
      end else begin
        nack_n = '0;
        cmd_n = 1'b1;
        case (state)
          ADDR:      state_n = CFG_WRITE;
          CFG_WRITE: state_n = CFG_READ;
          CFG_READ:
            if (bus.i_conf_mismatch) begin
              conf_n = conf_inc;
              if (conf_inc == CW'(CONF_RETRIES)) begin
                state_n = FAULT;
                code_n = 2'b10;
                fph_n = state[3:0];
                cmd_n = 1'b0;
              end else
                state_n = CFG_WRITE;
            end else begin
              conf_n = '0;
              state_n = bus.o_cfg_idx == IW'(N_CONF - 1) ? READING : CFG_WRITE;
              idx_n = bus.o_cfg_idx == IW'(N_CONF - 1) ? bus.o_cfg_idx : bus.o_cfg_idx + 1'b1;
            end
          default:   wr_n = 1'b1;
        endcase
      end
    end
  end
endmodule
